// File: rtl/mmio_pkg.sv
// mmio_pkg: shared definitions for the MMIO slot master.
//   - ADDR_W       : slot register address width (4)
//   - state_t      : master FSM state encoding
//   - ERR_*        : resp_err encodings
//   - slot_err()   : folds the slot error inputs into a resp_err code
package mmio_pkg;

  localparam int ADDR_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RD_ACCESS = 3'd1,
    ST_WR_PULSE  = 3'd2,
    ST_WR_WAIT   = 3'd3,
    ST_RESP      = 3'd4
  } state_t;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_SLVERR  = 2'b01;
  localparam logic [1:0] ERR_DECERR  = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  // A decode error means the slot never saw a valid register, so it
  // outranks anything the slot itself reports.
  function automatic logic [1:0] slot_err(input logic decode_error,
                                          input logic slave_error);
    if (decode_error)     return ERR_DECERR;
    else if (slave_error) return ERR_SLVERR;
    else                  return ERR_OK;
  endfunction

endpackage

// File: rtl/mmio_timeout_counter.sv
// mmio_timeout_counter: cycle counter used to bound how long the master
// waits for a slot to complete.
//   clk     in  : clock
//   arst_n  in  : asynchronous active-low reset (count -> 0)
//   clear   in  : restart the count at 0 (master entering an access)
//   enable  in  : count this cycle (master waiting on the slot)
//   expired out : this cycle's increment reaches LIMIT
// LIMIT is the number of enabled cycles allowed; legal range 1..65535.
module mmio_timeout_counter #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic arst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [15:0] LAST = 16'(LIMIT - 1);

  logic [15:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear)       count_d = 16'd0;
    else if (enable) count_d = count_q + 16'd1;
  end

  // Flagged combinationally in the cycle whose increment lands on LIMIT,
  // so the master leaves the wait state exactly LIMIT waiting cycles
  // after the strobe went up.
  assign expired = enable && !clear && (count_q == LAST);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) count_q <= 16'd0;
    else         count_q <= count_d;
  end

endmodule

// File: rtl/mmio_slot_master.sv
// mmio_slot_master: converts a valid/ready request into slot strobes
// (chip_select/read/write) and returns a valid/ready response.
//   Requester side : req_valid/req_ready/req_write/req_addr/req_wdata,
//                    resp_valid/resp_ready/resp_rdata/resp_err
//   Slot side      : chip_select/read/write/addr/wr_data out,
//                    rd_data/rd_done/wr_done/slave_error/decode_error in
//   clk, arst_n    : clock, asynchronous active-low reset
// Optional build macro MMIO_SLOT_MASTER_TIMEOUT_EN adds a wait bound of
// TIMEOUT_CYCLES cycles (resp_err=11); without it the master waits forever.
module mmio_slot_master
  import mmio_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic [1:0]        resp_err,
  output logic              chip_select,
  output logic              read,
  output logic              write,
  output logic [ADDR_W-1:0] addr,
  output logic [31:0]       wr_data,
  input  logic [31:0]       rd_data,
  input  logic              rd_done,
  input  logic              wr_done,
  input  logic              slave_error,
  input  logic              decode_error
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;
  logic [1:0]        resp_err_q, resp_err_d;
  logic              req_ready_q, req_ready_d;
  logic              timeout_hit;
  logic [1:0]        rd_err;

  assign rd_err = slot_err(decode_error, slave_error);

`ifdef MMIO_SLOT_MASTER_TIMEOUT_EN
  logic to_clear, to_enable;

  assign to_clear  = (state_q == ST_IDLE) && req_valid && req_ready_q;
  assign to_enable = (state_q == ST_RD_ACCESS) || (state_q == ST_WR_WAIT);

  mmio_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .arst_n  (arst_n),
    .clear   (to_clear),
    .enable  (to_enable),
    .expired (timeout_hit)
  );
`else
  // No wait bound in this build. A zero TIMEOUT_CYCLES is outside the
  // legal range; it shows up as immediate timeouts instead of being
  // silently accepted.
  assign timeout_hit = (TIMEOUT_CYCLES == 0);
`endif

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wr_data_d    = wr_data_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          addr_d       = req_addr;
          wr_data_d    = req_wdata;
          resp_rdata_d = 32'd0;
          resp_err_d   = ERR_OK;
          state_d      = req_write ? ST_WR_PULSE : ST_RD_ACCESS;
        end
      end
      ST_RD_ACCESS: begin
        // rd_done is checked first so a completion in the expiry cycle wins.
        if (rd_done) begin
          resp_err_d   = rd_err;
          resp_rdata_d = (rd_err == ERR_OK) ? rd_data : 32'd0;
          state_d      = ST_RESP;
        end else if (timeout_hit) begin
          resp_err_d   = ERR_TIMEOUT;
          resp_rdata_d = 32'd0;
          state_d      = ST_RESP;
        end
      end
      ST_WR_PULSE: begin
        // The write's error status is only meaningful during the pulse.
        resp_err_d   = rd_err;
        resp_rdata_d = 32'd0;
        state_d      = ST_WR_WAIT;
      end
      ST_WR_WAIT: begin
        if (wr_done) begin
          state_d = ST_RESP;
        end else if (timeout_hit) begin
          resp_err_d = ERR_TIMEOUT;
          state_d    = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered so that req_ready stays low while reset is held and rises
  // on the first clock edge after release.
  assign req_ready_d = (state_d == ST_IDLE);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      wr_data_q    <= 32'd0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= ERR_OK;
      req_ready_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wr_data_q    <= wr_data_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      req_ready_q  <= req_ready_d;
    end
  end

  // Strobes decode straight from the state register, so they cannot
  // overlap and they clear the instant reset asserts.
  assign chip_select = (state_q == ST_RD_ACCESS) || (state_q == ST_WR_PULSE);
  assign read        = (state_q == ST_RD_ACCESS);
  assign write       = (state_q == ST_WR_PULSE);
  assign resp_valid  = (state_q == ST_RESP);
  assign req_ready   = req_ready_q;
  assign resp_rdata  = resp_rdata_q;
  assign resp_err    = resp_err_q;
  assign addr        = addr_q;
  assign wr_data     = wr_data_q;

endmodule

// File: tb/tb_mmio_slot_master.sv
// tb_mmio_slot_master: scoreboard bench for mmio_slot_master.
// A behavioural slot answers the strobes on the falling edge according to
// the cfg_* settings; each request pushes its expected response, which is
// popped and compared when resp_valid appears. Built with
// MMIO_SLOT_MASTER_TIMEOUT_EN it also exercises the timeout (limit 4).
module tb_mmio_slot_master;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        req_valid, req_ready, req_write;
  logic [3:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic        chip_select, read, write;
  logic [3:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        rd_done, wr_done, slave_error, decode_error;

  always #5 clk = ~clk;

  mmio_slot_master #(.TIMEOUT_CYCLES(4)) dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .chip_select  (chip_select),
    .read         (read),
    .write        (write),
    .addr         (addr),
    .wr_data      (wr_data),
    .rd_data      (rd_data),
    .rd_done      (rd_done),
    .wr_done      (wr_done),
    .slave_error  (slave_error),
    .decode_error (decode_error)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural slot ----------------
  int          cfg_rd_lat = 0;   // strobe cycles before rd_done (-1 = never)
  int          cfg_wr_lat = 0;   // WR_WAIT cycles before wr_done (-1 = never)
  logic [31:0] cfg_rdata  = 32'd0;
  logic        cfg_slv    = 1'b0;
  logic        cfg_dec    = 1'b0;
  logic        cfg_force_done = 1'b0;  // stray dones outside any access
  int          rd_cycles = 0, wr_cycles = 0, cs_bad = 0, overlap = 0;
  int          rd_cyc = 0, wait_cyc = 0;
  bit          in_wait = 0;

  initial begin
    rd_done = 0; wr_done = 0; slave_error = 0; decode_error = 0; rd_data = 32'hDEAD_BEEF;
    forever begin
      @(negedge clk);
      if (read && write) overlap++;
      if (chip_select !== (read | write)) cs_bad++;
      if (read) begin
        rd_done      = (cfg_rd_lat >= 0) && (rd_cyc == cfg_rd_lat);
        rd_data      = cfg_rdata;
        slave_error  = cfg_slv;
        decode_error = cfg_dec;
        rd_cyc++;
        rd_cycles++;
      end else begin
        rd_cyc       = 0;
        rd_done      = cfg_force_done;
        rd_data      = 32'hDEAD_BEEF;
        slave_error  = 1'b0;
        decode_error = 1'b0;
      end
      if (!arst_n || resp_valid) in_wait = 0;
      if (write) begin
        slave_error  = cfg_slv;
        decode_error = cfg_dec;
        wr_cycles++;
        in_wait  = 1;
        wait_cyc = 0;
        wr_done  = cfg_force_done;
      end else if (in_wait) begin
        wr_done = cfg_force_done || ((cfg_wr_lat >= 0) && (wait_cyc == cfg_wr_lat));
        wait_cyc++;
      end else begin
        wr_done = cfg_force_done;
      end
    end
  end

  task automatic set_slot(input int rl, input int wl, input logic [31:0] d,
                          input logic slv, input logic dec);
    cfg_rd_lat = rl; cfg_wr_lat = wl; cfg_rdata = d; cfg_slv = slv; cfg_dec = dec;
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  err;
    int          lat;
    int          strb;
  } exp_t;
  exp_t sb[$];

  task automatic run_txn(input string name, input logic wr, input logic [3:0] a,
                         input logic [31:0] wd, input logic [31:0] exp_rd,
                         input logic [1:0] exp_err, input int exp_lat,
                         input int exp_strb, input int hold);
    exp_t e;
    int   lat;
    e.rdata = exp_rd; e.err = exp_err; e.lat = exp_lat; e.strb = exp_strb;
    sb.push_back(e);
    @(negedge clk);
    check({name, ".req_ready"}, {31'd0, req_ready}, 32'd1);
    rd_cycles = 0; wr_cycles = 0;
    req_valid = 1; req_write = wr; req_addr = a; req_wdata = wd;
    resp_ready = (hold == 0);
    @(posedge clk);
    #1;
    req_valid = 0; req_addr = 4'($urandom); req_wdata = $urandom;
    check({name, ".addr"}, {28'd0, addr}, {28'd0, a});
    check({name, ".wr_data"}, wr_data, wd);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_valid && lat < 100);
    e = sb.pop_front();
    check({name, ".resp_seen"}, {31'd0, resp_valid}, 32'd1);
    check({name, ".rdata"}, resp_rdata, e.rdata);
    check({name, ".err"}, {30'd0, resp_err}, {30'd0, e.err});
    check({name, ".latency"}, lat, e.lat);
    check({name, ".req_ready_in_resp"}, {31'd0, req_ready}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({name, ".hold_valid"}, {31'd0, resp_valid}, 32'd1);
      check({name, ".hold_rdata"}, resp_rdata, e.rdata);
      check({name, ".hold_err"}, {30'd0, resp_err}, {30'd0, e.err});
      check({name, ".hold_req_ready"}, {31'd0, req_ready}, 32'd0);
    end
    resp_ready = 1;
    @(posedge clk);
    #1;
    check({name, ".resp_done"}, {31'd0, resp_valid}, 32'd0);
    check({name, ".ready_after"}, {31'd0, req_ready}, 32'd1);
    if (wr) begin
      check({name, ".write_cycles"}, wr_cycles, 1);
      check({name, ".read_cycles"}, rd_cycles, 0);
    end else begin
      check({name, ".read_cycles"}, rd_cycles, e.strb);
      check({name, ".write_cycles"}, wr_cycles, 0);
    end
    $display("txn %-12s %s addr=%0d wdata=0x%08h -> rdata=0x%08h err=%0d lat=%0d",
             name, wr ? "WR" : "RD", a, wd, resp_rdata, resp_err, lat);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".cs"},         {31'd0, chip_select}, 32'd0);
    check({tag, ".read"},       {31'd0, read},        32'd0);
    check({tag, ".write"},      {31'd0, write},       32'd0);
    check({tag, ".resp_valid"}, {31'd0, resp_valid},  32'd0);
    check({tag, ".resp_rdata"}, resp_rdata,           32'd0);
    check({tag, ".resp_err"},   {30'd0, resp_err},    32'd0);
    check({tag, ".addr"},       {28'd0, addr},        32'd0);
    check({tag, ".wr_data"},    wr_data,              32'd0);
    check({tag, ".req_ready"},  {31'd0, req_ready},   32'd0);
  endtask

  task automatic do_reset(input string tag);
    #2 arst_n = 0;
    #1 check_all_zero(tag);
    @(negedge clk);
    @(negedge clk);
    arst_n = 1;
    @(posedge clk);
    #1 check({tag, ".ready_first_edge"}, {31'd0, req_ready}, 32'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic        r_wr, r_slv, r_dec;
    logic [31:0] r_d, r_wd;
    logic [3:0]  r_a;
    int          r_lat;
    int          seen;

    arst_n = 0; req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; resp_ready = 1;
    do_reset("reset");

    set_slot(0, 0, 32'h0, 0, 0);
    run_txn("wr_basic", 1, 4'd1, 32'h64, 32'd0, 2'b00, 3, 0, 0);
    set_slot(0, 0, 32'h64, 0, 0);
    run_txn("rd_basic", 0, 4'd1, 32'h0, 32'h64, 2'b00, 2, 1, 0);
    set_slot(0, 0, 32'h0, 1, 0);
    run_txn("wr_slverr", 1, 4'd0, 32'hCAFE_0001, 32'd0, 2'b01, 3, 0, 0);
    set_slot(0, 0, 32'h1234, 1, 1);
    run_txn("rd_decerr", 0, 4'd9, 32'h0, 32'd0, 2'b10, 2, 1, 0);
    set_slot(0, 0, 32'h5555, 1, 0);
    run_txn("rd_slverr", 0, 4'd4, 32'h0, 32'd0, 2'b01, 2, 1, 0);
    set_slot(2, 0, 32'hA5A5_0001, 0, 0);
    run_txn("rd_slow", 0, 4'd3, 32'h0, 32'hA5A5_0001, 2'b00, 4, 3, 0);
    set_slot(0, 3, 32'h0, 0, 0);
    run_txn("wr_slow", 1, 4'd7, 32'h0BAD_F00D, 32'd0, 2'b00, 6, 0, 0);
    set_slot(0, 0, 32'h7777_8888, 0, 0);
    run_txn("rd_hold", 0, 4'd15, 32'h0, 32'h7777_8888, 2'b00, 2, 1, 10);

    for (int i = 0; i < 6; i++) begin
      r_wr = 1'($urandom); r_a = 4'($urandom); r_d = $urandom; r_wd = $urandom;
      r_slv = ($urandom_range(0, 3) == 0); r_dec = ($urandom_range(0, 3) == 0);
      r_lat = $urandom_range(0, 2);
      if (r_wr) begin
        set_slot(0, r_lat, r_d, r_slv, r_dec);
        run_txn($sformatf("rand%0d", i), 1, r_a, r_wd, 32'd0,
                r_dec ? 2'b10 : (r_slv ? 2'b01 : 2'b00), 3 + r_lat, 0, 0);
      end else begin
        set_slot(r_lat, 0, r_d, r_slv, r_dec);
        run_txn($sformatf("rand%0d", i), 0, r_a, r_wd,
                (r_dec || r_slv) ? 32'd0 : r_d,
                r_dec ? 2'b10 : (r_slv ? 2'b01 : 2'b00), 2 + r_lat, 1 + r_lat, 0);
      end
    end

`ifdef MMIO_SLOT_MASTER_TIMEOUT_EN
    set_slot(-1, 0, 32'h1111, 0, 0);
    run_txn("rd_timeout", 0, 4'd2, 32'h0, 32'd0, 2'b11, 5, 4, 0);
    set_slot(3, 0, 32'h2222_3333, 0, 0);
    run_txn("rd_done_tie", 0, 4'd2, 32'h0, 32'h2222_3333, 2'b00, 5, 4, 0);
    set_slot(0, -1, 32'h0, 0, 0);
    run_txn("wr_timeout", 1, 4'd5, 32'h0000_0042, 32'd0, 2'b11, 6, 0, 0);
`else
    // Without the timeout a silent slot keeps the read strobe up forever.
    set_slot(-1, 0, 32'h1111, 0, 0);
    @(negedge clk);
    req_valid = 1; req_write = 0; req_addr = 4'd2;
    @(posedge clk);
    #1 req_valid = 0;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (resp_valid || !read) seen++;
    end
    check("no_timeout.waiting", seen, 0);
    $display("txn %-12s RD addr=2 still waiting after 30 cycles", "no_timeout");
    do_reset("no_timeout_reset");
`endif

    // Reset during WR_WAIT drops the write; stray dones afterwards are ignored.
    set_slot(0, -1, 32'h0, 0, 0);
    @(negedge clk);
    req_valid = 1; req_write = 1; req_addr = 4'd6; req_wdata = 32'h1357_9BDF;
    @(posedge clk);
    #1 req_valid = 0;
    @(negedge clk);
    check("rst_wr.pulse", {31'd0, write}, 32'd1);
    @(negedge clk);
    check("rst_wr.waiting", {31'd0, write}, 32'd0);
    cfg_force_done = 1;
    do_reset("rst_wr");
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (resp_valid || chip_select) seen++;
    end
    check("rst_wr.no_resp", seen, 0);
    cfg_force_done = 0;
    $display("txn %-12s WR addr=6 dropped by reset, no response", "rst_wr");

    set_slot(0, 0, 32'h0F0F_0F0F, 0, 0);
    run_txn("rd_after_rst", 0, 4'd8, 32'h0, 32'h0F0F_0F0F, 2'b00, 2, 1, 0);

    check("strobe_overlap", overlap, 0);
    check("cs_decode", cs_bad, 0);
    check("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
